// File: rtl/dispensador_produto.sv
// Dispensing controller: drives the product motor, then ejects coins one unit at a time.
// Optional feature macro: DISPENSADOR_TROCO_EN (change is returned on a sale when defined).
`timescale 1ns/1ps

module dispensador_produto #(
   parameter int MOTOR_CYCLES = 50,
   parameter int COIN_PULSE   = 10,
   parameter int COIN_GAP     = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       LP,
   input  logic       DM,
   input  logic [3:0] codProd,
   input  logic [3:0] valorMoedas,
   input  logic [2:0] valorProduto,
   output logic       motor_en,
   output logic [3:0] motor_sel,
   output logic       coin_eject,
   output logic       busy,
   output logic       FIM
);

   localparam int CNT_MAX = (MOTOR_CYCLES > COIN_PULSE) ?
                            ((MOTOR_CYCLES > COIN_GAP) ? MOTOR_CYCLES : COIN_GAP) :
                            ((COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] MOTOR_LD = CNT_W'(MOTOR_CYCLES);
   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(COIN_PULSE);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(COIN_GAP);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_MOTOR  = 3'd1,
      S_EJ_ON  = 3'd2,
      S_EJ_GAP = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [3:0]       coins, coins_nx;
   logic [3:0]       sel_nx;
   logic [3:0]       sale_coins;
   logic             LP_q, DM_q;
   logic             lp_rise, dm_rise;
   logic             motor_en_nx, coin_eject_nx, busy_nx, fim_nx;

   assign lp_rise = LP & ~LP_q;
   assign dm_rise = DM & ~DM_q;

`ifdef DISPENSADOR_TROCO_EN
   // Change owed on a sale; a price above the paid amount yields no change rather than wrapping.
   function automatic logic [3:0] sat0(input logic [3:0] paid, input logic [2:0] price);
      if (paid < {1'b0, price})
         return 4'd0;
      else
         return paid - {1'b0, price};
   endfunction

   assign sale_coins = sat0(valorMoedas, valorProduto);
`else
   logic unused_valor_produto;
   assign unused_valor_produto = ^valorProduto;
   assign sale_coins = 4'd0;
`endif

   // State register, working registers and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         coins      <= 4'd0;
         LP_q       <= 1'b0;
         DM_q       <= 1'b0;
         motor_sel  <= 4'd0;
         motor_en   <= 1'b0;
         coin_eject <= 1'b0;
         busy       <= 1'b0;
         FIM        <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         coins      <= coins_nx;
         LP_q       <= LP;
         DM_q       <= DM;
         motor_sel  <= sel_nx;
         motor_en   <= motor_en_nx;
         coin_eject <= coin_eject_nx;
         busy       <= busy_nx;
         FIM        <= fim_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      coins_nx = coins;
      sel_nx   = motor_sel;
      case (state)
         S_IDLE: begin
            // A refund request wins over a simultaneous release request.
            if (dm_rise) begin
               coins_nx = valorMoedas;
               if (valorMoedas != 4'd0) begin
                  state_nx = S_EJ_ON;
                  cnt_nx   = PULSE_LD;
               end else begin
                  state_nx = S_DONE;
               end
            end else if (lp_rise) begin
               sel_nx   = codProd;
               coins_nx = sale_coins;
               cnt_nx   = MOTOR_LD;
               state_nx = S_MOTOR;
            end
         end
         S_MOTOR: begin
            if (cnt <= CNT_ONE) begin
               if (coins != 4'd0) begin
                  state_nx = S_EJ_ON;
                  cnt_nx   = PULSE_LD;
               end else begin
                  state_nx = S_DONE;
                  cnt_nx   = '0;
               end
            end else begin
               cnt_nx = cnt - CNT_ONE;
            end
         end
         S_EJ_ON: begin
            if (cnt <= CNT_ONE) begin
               coins_nx = coins - 4'd1;
               if (coins != 4'd1) begin
                  state_nx = S_EJ_GAP;
                  cnt_nx   = GAP_LD;
               end else begin
                  state_nx = S_DONE;
                  cnt_nx   = '0;
               end
            end else begin
               cnt_nx = cnt - CNT_ONE;
            end
         end
         S_EJ_GAP: begin
            if (cnt <= CNT_ONE) begin
               state_nx = S_EJ_ON;
               cnt_nx   = PULSE_LD;
            end else begin
               cnt_nx = cnt - CNT_ONE;
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
         end
         default: begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
            coins_nx = 4'd0;
         end
      endcase
   end

   // Outputs are decoded from the next state so that they are registered yet aligned with it.
   always_comb begin
      motor_en_nx   = (state_nx == S_MOTOR);
      coin_eject_nx = (state_nx == S_EJ_ON);
      busy_nx       = (state_nx != S_IDLE);
      fim_nx        = (state_nx == S_DONE);
   end

endmodule

// File: tb/tb_dispensador_produto.sv
// Bench for dispensador_produto: table vectors, hand sequences and random transactions vs a trace model.
`timescale 1ns/1ps

module tb_dispensador_produto;

   localparam int MC = 4;
   localparam int CP = 2;
   localparam int CG = 1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       LP = 1'b0;
   logic       DM = 1'b0;
   logic [3:0] codProd = 4'd0;
   logic [3:0] valorMoedas = 4'd0;
   logic [2:0] valorProduto = 3'd0;
   logic       motor_en;
   logic [3:0] motor_sel;
   logic       coin_eject;
   logic       busy;
   logic       FIM;

   int n_chk  = 0;
   int n_pass = 0;

   dispensador_produto #(
      .MOTOR_CYCLES(MC),
      .COIN_PULSE  (CP),
      .COIN_GAP    (CG)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .LP          (LP),
      .DM          (DM),
      .codProd     (codProd),
      .valorMoedas (valorMoedas),
      .valorProduto(valorProduto),
      .motor_en    (motor_en),
      .motor_sel   (motor_sel),
      .coin_eject  (coin_eject),
      .busy        (busy),
      .FIM         (FIM)
   );

   always #5 clk = ~clk;

   typedef struct {
      int lp;
      int dm;
      int cod;
      int moedas;
      int prod;
      int exp_motor;
      int exp_k;
      int exp_len;
   } vec_t;

   task automatic chk(input string what, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", what, act, exp);
   endtask

   // Coins the spec says a transaction returns.
   function automatic int model_k(input int dm, input int moedas, input int prod);
      if (dm != 0) return moedas;
`ifdef DISPENSADOR_TROCO_EN
      return (moedas > prod) ? moedas - prod : 0;
`else
      return prod * 0;
`endif
   endfunction

   function automatic int model_len(input int sale, input int k);
      int t;
      t = (k > 0) ? k * CP + (k - 1) * CG : 0;
      return (sale != 0 ? MC : 0) + t + 1;
   endfunction

   // Assumes the request was applied just before the coming rising edge.
   task automatic check_trace(input string tag, input int sale, input int k, input int cod,
                              input int exp_len, input int glitch);
      logic [3:0] expq[$];
      logic [3:0] obs;
      int fim_at;
      int fim_cnt;
      if (sale != 0) repeat (MC) expq.push_back(4'b1100);
      for (int c = 0; c < k; c++) begin
         repeat (CP) expq.push_back(4'b1010);
         if (c < k - 1) repeat (CG) expq.push_back(4'b1000);
      end
      expq.push_back(4'b1001);
      expq.push_back(4'b0000);
      fim_at  = -1;
      fim_cnt = 0;
      for (int i = 0; i < expq.size(); i++) begin
         @(negedge clk);
         obs = {busy, motor_en, coin_eject, FIM};
         chk($sformatf("%s cyc%0d {busy,motor,coin,fim}", tag, i + 1), int'(obs), int'(expq[i]));
         if (expq[i][2]) chk($sformatf("%s cyc%0d motor_sel", tag, i + 1), int'(motor_sel), cod);
         if (FIM) begin
            fim_cnt++;
            if (fim_at < 0) fim_at = i + 1;
         end
         if (i == 0) begin
            LP = 1'b0;
            DM = 1'b0;
         end
         if (glitch != 0 && i == 1) begin
            LP = 1'b1;
            DM = 1'b1;
         end
         if (glitch != 0 && i == 2) begin
            LP = 1'b0;
            DM = 1'b0;
         end
      end
      repeat (2) begin
         @(negedge clk);
         if (FIM) fim_cnt++;
      end
      chk($sformatf("%s FIM cycle", tag), fim_at, exp_len);
      chk($sformatf("%s FIM count", tag), fim_cnt, 1);
      chk($sformatf("%s idle busy", tag), int'(busy), 0);
   endtask

   task automatic apply(input int lp, input int dm, input int cod, input int moedas, input int prod);
      @(negedge clk);
      LP           = lp[0];
      DM           = dm[0];
      codProd      = 4'(cod);
      valorMoedas  = 4'(moedas);
      valorProduto = 3'(prod);
   endtask

   vec_t tbl[7];

   initial begin
`ifdef DISPENSADOR_TROCO_EN
      tbl[0] = '{1, 0, 5, 7, 4, 1, 3, 13};
      tbl[5] = '{1, 0, 3, 7, 2, 1, 5, 19};
`else
      tbl[0] = '{1, 0, 5, 7, 4, 1, 0, 5};
      tbl[5] = '{1, 0, 3, 7, 2, 1, 0, 5};
`endif
      tbl[1] = '{1, 0, 9, 3, 3, 1, 0, 5};
      tbl[2] = '{0, 1, 2, 2, 1, 0, 2, 6};
      tbl[3] = '{0, 1, 4, 0, 0, 0, 0, 1};
      tbl[4] = '{1, 1, 8, 1, 0, 0, 1, 3};
      tbl[6] = '{1, 0, 12, 2, 5, 1, 0, 5};

      // Reset state, with LP held high through reset
      LP = 1'b1; codProd = 4'd10; valorMoedas = 4'd4; valorProduto = 3'd1;
      repeat (3) @(negedge clk);
      chk("reset outputs", int'({busy, motor_en, coin_eject, FIM}), 0);
      chk("reset motor_sel", int'(motor_sel), 0);
      reset = 1'b0;
      check_trace("held-LP", 1, model_k(0, 4, 1), 10, model_len(1, model_k(0, 4, 1)), 0);

      foreach (tbl[i])
         begin
            apply(tbl[i].lp, tbl[i].dm, tbl[i].cod, tbl[i].moedas, tbl[i].prod);
            check_trace($sformatf("vec%0d", i), tbl[i].exp_motor, tbl[i].exp_k, tbl[i].cod,
                        tbl[i].exp_len, 0);
         end

      // Rises during MOTOR are ignored
      apply(1, 0, 6, 5, 5);
      check_trace("glitch", 1, 0, 6, MC + 1, 1);

      // Reset during EJ_GAP
      apply(0, 1, 0, 2, 0);
      @(negedge clk); DM = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("gap busy", int'(busy), 1);
      chk("gap coin_eject", int'(coin_eject), 0);
      reset = 1'b1;
      @(negedge clk);
      chk("rst-in-gap outputs", int'({busy, motor_en, coin_eject, FIM}), 0);
      chk("rst-in-gap motor_sel", int'(motor_sel), 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("post-reset idle", int'({busy, motor_en, coin_eject, FIM}), 0);

      // Random transactions
      for (int t = 0; t < 40; t++) begin
         int kind, cod, m, p, k, sale;
         kind = int'($urandom_range(0, 2));
         cod  = int'($urandom_range(0, 15));
         m    = int'($urandom_range(0, 15));
         p    = int'($urandom_range(0, 7));
         sale = (kind == 0) ? 1 : 0;
         k    = model_k(sale ? 0 : 1, m, p);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         apply((kind != 1) ? 1 : 0, (kind != 0) ? 1 : 0, cod, m, p);
         check_trace($sformatf("rnd%0d", t), sale, k, cod, model_len(sale, k), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dispensador_produto.md
# dispensador_produto

Dispensing controller downstream of the vending-machine top level. Consumes the release decision (`LP`) and the coin-return decision (`DM`), along with the selected product code and coin values. Drives the product motor for a fixed time, then ejects coins one unit at a time: change on a sale, or the full amount on a refund. Reports completion with a one-cycle `FIM` pulse that feeds back to the main control FSM.

## Interface
Parameters:
- `MOTOR_CYCLES`, default 50: number of cycles `motor_en` stays high per sale, ≥1.
- `COIN_PULSE`, default 10: high time of each `coin_eject` pulse in cycles, ≥1.
- `COIN_GAP`, default 10: low time between consecutive coin pulses in cycles, ≥1.

Ports:
- `clk` in 1: single system clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `LP` in 1: release-product request, level; acted on at its rising edge.
- `DM` in 1: return-coins request, level; acted on at its rising edge.
- `codProd` in 4: selected product code, sampled on the accepted edge.
- `valorMoedas` in 4: accumulated coin value, sampled on the accepted edge.
- `valorProduto` in 3: product price, sampled on the accepted edge.
- `motor_en` out 1: product motor drive.
- `motor_sel` out 4: latched product code, valid while `motor_en` is high.
- `coin_eject` out 1: one pulse per coin unit ejected.
- `busy` out 1: high in every state except IDLE.
- `FIM` out 1: one-cycle completion pulse.

## Operation
- Edge detection: the block registers `LP_q`/`DM_q`.
  - A rise is `LP & ~LP_q` (likewise for `DM`).
  - `LP_q`/`DM_q` update every cycle, including while busy.
- States: IDLE, MOTOR, EJ_ON, EJ_GAP, DONE.
- IDLE, on an `LP` rise with no `DM` rise:
  - latch `motor_sel <= codProd`;
  - set `coins <= sat0(valorMoedas - {1'b0,valorProduto})`, 4-bit, saturating at 0 when the price exceeds the coins;
  - load the motor counter with `MOTOR_CYCLES`; go to MOTOR.
- IDLE, on a `DM` rise (with or without a simultaneous `LP` rise; DM wins): set `coins <= valorMoedas`; go to EJ_ON if `coins≠0`, else DONE. The motor is never driven on this path.
- MOTOR: `motor_en=1`. The counter decrements each cycle. At 1, go to EJ_ON if `coins≠0`, else DONE.
- EJ_ON: `coin_eject=1` for `COIN_PULSE` cycles, then decrement `coins`. Go to EJ_GAP if the new `coins≠0`, else DONE.
- EJ_GAP: `coin_eject=0` for `COIN_GAP` cycles, then go to EJ_ON.
- DONE: `FIM=1` for exactly one cycle, then IDLE.
- Rises of `LP`/`DM` outside IDLE are ignored and not queued.
- Reset in any state:
  - next state is IDLE;
  - all outputs go to 0, including `motor_sel=0`;
  - counters and `coins` are cleared, and `LP_q=DM_q=0`.
- Consequence of clearing `LP_q`/`DM_q`: an `LP`/`DM` held high through reset counts as a rise on the first cycle after `reset` falls.

## Timing
- Reset values: `motor_en=0`, `motor_sel=0`, `coin_eject=0`, `busy=0`, `FIM=0`.
- All outputs are registered.
- Edge sampled at clock edge n:
  - `busy` and the first active output (`motor_en` or `coin_eject`) are high from n+1.
  - On the zero-coin refund path, `FIM` is high in cycle n+1.
- Sale total, from edge n until `FIM` deasserts:
  - `MOTOR_CYCLES + k·COIN_PULSE + (k−1)·COIN_GAP + 1` cycles, where k is the number of change coins;
  - `MOTOR_CYCLES + 1` when k=0.
- Refund total: `k·COIN_PULSE + (k−1)·COIN_GAP + 1` cycles.
- `busy` falls in the cycle after `FIM`. A new edge is accepted on that same cycle.

## Configuration
- `DISPENSADOR_TROCO_EN` defined:
  - the sale path computes and ejects change as described above.
- `DISPENSADOR_TROCO_EN` not defined:
  - the sale path forces `coins=0` (MOTOR→DONE); no change is returned;
  - the refund path (`DM`) is unchanged;
  - `valorProduto` is unused.

## Test plan
All scenarios use `MOTOR_CYCLES=4`, `COIN_PULSE=2`, `COIN_GAP=1`, with `DISPENSADOR_TROCO_EN` defined unless stated.
- Sale with change: `LP` rise, `codProd=5`, `valorMoedas=7`, `valorProduto=4` -> `motor_sel=5`; `motor_en` high for 4 cycles; 3 `coin_eject` pulses, each 2 high and 1 low between; `FIM` high 1 cycle; 13 cycles total.
- Exact payment: `valorMoedas=3`, `valorProduto=3` -> motor high 4 cycles, no coin pulses, `FIM` in cycle 5.
- Refund: `DM` rise, `valorMoedas=2` -> no `motor_en`; 2 coin pulses; `FIM` at cycle 6. Zero-value refund: `valorMoedas=0` -> `FIM` in the next cycle.
- Simultaneous `LP`+`DM` rise with `valorMoedas=1` -> refund path: `motor_en` stays 0; 1 coin pulse.
- `LP` pulsed again mid-MOTOR -> ignored; exactly one `FIM`. Separately, `reset` asserted during EJ_GAP -> all outputs 0 on the next cycle, state IDLE.
- Build without `DISPENSADOR_TROCO_EN`: sale with `valorMoedas=7`, `valorProduto=2` -> 4 motor cycles, no coin pulses, `FIM`.
